// File: rtl/bus_region_if.sv
// Core-side bus between the CPU fetch/load-store port, the region controller and its slaves.
// The slave modport is the controller's view; master covers the core and the slave ready lines.
interface bus_region_if #(
    parameter int ADDR_W    = 32,
    parameter int N_REGIONS = 4
);
    logic                 bus_req;
    logic [ADDR_W-1:0]    bus_addr;
    logic                 bus_ready;
    logic                 bus_err;
    logic [N_REGIONS-1:0] sel;
    logic [N_REGIONS-1:0] ext_rdy;

    modport master (
        output bus_req, bus_addr, ext_rdy,
        input  bus_ready, bus_err, sel
    );

    modport slave (
        input  bus_req, bus_addr, ext_rdy,
        output bus_ready, bus_err, sel
    );
endinterface

// File: rtl/bus_region_ctrl.sv
// Registered base/mask address decoder with per-region wait states or external ready + timeout,
// one-cycle ready/error response and first-fault address capture.
module bus_region_dec #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] mask,
    output logic              hit
);
    assign hit = ((addr & ~mask) == base);
endmodule

module bus_region_ctrl #(
    parameter int                          ADDR_W      = 32,
    parameter int                          N_REGIONS   = 4,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = {32'h08000000, 32'h04010000,
                                                          32'h04000000, 32'h00000000},
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = {32'h03FFFFFF, 32'h0000000F,
                                                          32'h0000FFFF, 32'h00000FFF},
    parameter logic [N_REGIONS*4-1:0]      REGION_WAIT = {4'd2, 4'd0, 4'd1, 4'd0},
    parameter logic [N_REGIONS-1:0]        REGION_EXT  = '0,
    parameter int                          TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_region_if.slave       bus,
    input  logic              fault_clr,
    output logic              fault_valid,
    output logic [ADDR_W-1:0] fault_addr
);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (TO_W > 4) ? TO_W : 4;
    localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_REGIONS-1:0] sel_q, sel_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 err_q, err_d;

    logic [1:0]           rst_sync_q;
    logic                 rst_i_n;
    logic [N_REGIONS-1:0] hit;
    logic [N_REGIONS-1:0] hit_oh;
    logic [IDX_W-1:0]     hit_idx;
    logic                 hit_any;
    logic [3:0]           cur_wait;
    logic                 cur_ext;
    logic                 cur_rdy;
    logic                 fault_ev;
    logic [ADDR_W-1:0]    fault_ev_addr;

    // Assert immediately, release two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_i_n = rst_sync_q[1];

    for (genvar i = 0; i < N_REGIONS; i++) begin : g_dec
        bus_region_dec #(.ADDR_W(ADDR_W)) u_dec (
            .addr (bus.bus_addr),
            .base (REGION_BASE[i*ADDR_W +: ADDR_W]),
            .mask (REGION_MASK[i*ADDR_W +: ADDR_W]),
            .hit  (hit[i])
        );
    end

    // Scan high to low so the lowest overlapping window is the last one written.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        hit_oh          = '0;
        hit_oh[hit_idx] = hit_any;
    end

    assign cur_wait = REGION_WAIT[4*int'(idx_q) +: 4];
    assign cur_ext  = REGION_EXT[idx_q];
    assign cur_rdy  = bus.ext_rdy[idx_q];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sel_d         = sel_q;
        idx_d         = idx_q;
        addr_d        = addr_q;
        err_d         = err_q;
        fault_ev      = 1'b0;
        fault_ev_addr = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.bus_req) begin
                    addr_d = bus.bus_addr;
                    if (hit_any) begin
                        sel_d   = hit_oh;
                        idx_d   = hit_idx;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = BUSY;
                    end else begin
                        err_d         = 1'b1;
                        fault_ev      = 1'b1;
                        fault_ev_addr = bus.bus_addr;
                        state_d       = RESP;
                    end
                end
            end
            BUSY: begin
                if (cur_ext) begin
                    // Ready checked first so it wins on the timeout-limit cycle.
                    if (cur_rdy) begin
                        sel_d   = '0;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        sel_d    = '0;
                        err_d    = 1'b1;
                        fault_ev = 1'b1;
                        state_d  = RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_q == CNT_W'(cur_wait)) begin
                    sel_d   = '0;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                sel_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    // A clear in the same cycle as a new fault frees the slot for the new address.
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            fault_valid <= 1'b0;
            fault_addr  <= '0;
        end else if (fault_ev && (!fault_valid || fault_clr)) begin
            fault_valid <= 1'b1;
            fault_addr  <= fault_ev_addr;
        end else if (fault_clr) begin
            fault_valid <= 1'b0;
            fault_addr  <= '0;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.bus_ready = (state_q == RESP) && !err_q;
    assign bus.bus_err   = (state_q == RESP) && err_q;
endmodule

// File: tb/tb_bus_region_ctrl.sv
// Bench for bus_region_ctrl: three configurations (default, ext-ready graphics, widened ROM window)
// driven by a vector table, hand sequences and random traffic against a rule-level model.
module tb_bus_region_ctrl;
    logic clk;
    logic [2:0]       rst_n_d;
    logic [2:0]       req_d;
    logic [2:0][31:0] addr_d;
    logic [2:0][3:0]  ext_d;
    logic [2:0]       fclr_d;
    logic [2:0]       rdy_o, err_o, fv_o;
    logic [2:0][3:0]  sel_o;
    logic [2:0][31:0] fa_o;

    int checks;
    int failures;
    bit        mfv [3];
    logic [31:0] mfa [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bus_region_if #(.ADDR_W(32), .N_REGIONS(4)) if_a ();
    bus_region_if #(.ADDR_W(32), .N_REGIONS(4)) if_b ();
    bus_region_if #(.ADDR_W(32), .N_REGIONS(4)) if_c ();

    assign if_a.bus_req = req_d[0];  assign if_a.bus_addr = addr_d[0];  assign if_a.ext_rdy = ext_d[0];
    assign if_b.bus_req = req_d[1];  assign if_b.bus_addr = addr_d[1];  assign if_b.ext_rdy = ext_d[1];
    assign if_c.bus_req = req_d[2];  assign if_c.bus_addr = addr_d[2];  assign if_c.ext_rdy = ext_d[2];
    assign rdy_o[0] = if_a.bus_ready; assign err_o[0] = if_a.bus_err; assign sel_o[0] = if_a.sel;
    assign rdy_o[1] = if_b.bus_ready; assign err_o[1] = if_b.bus_err; assign sel_o[1] = if_b.sel;
    assign rdy_o[2] = if_c.bus_ready; assign err_o[2] = if_c.bus_err; assign sel_o[2] = if_c.sel;

    bus_region_ctrl u_dut_a (
        .clk(clk), .rst_n(rst_n_d[0]), .bus(if_a), .fault_clr(fclr_d[0]),
        .fault_valid(fv_o[0]), .fault_addr(fa_o[0])
    );
    bus_region_ctrl #(.REGION_EXT(4'b0100), .TIMEOUT(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n_d[1]), .bus(if_b), .fault_clr(fclr_d[1]),
        .fault_valid(fv_o[1]), .fault_addr(fa_o[1])
    );
    bus_region_ctrl #(.REGION_MASK({32'h03FFFFFF, 32'h0000000F, 32'h0000FFFF, 32'h07FFFFFF})) u_dut_c (
        .clk(clk), .rst_n(rst_n_d[2]), .bus(if_c), .fault_clr(fclr_d[2]),
        .fault_valid(fv_o[2]), .fault_addr(fa_o[2])
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_base(int r);
        case (r)
            0:       return 32'h00000000;
            1:       return 32'h04000000;
            2:       return 32'h04010000;
            default: return 32'h08000000;
        endcase
    endfunction

    function automatic logic [31:0] m_mask(int d, int r);
        case (r)
            0:       return (d == 2) ? 32'h07FFFFFF : 32'h00000FFF;
            1:       return 32'h0000FFFF;
            2:       return 32'h0000000F;
            default: return 32'h03FFFFFF;
        endcase
    endfunction

    function automatic int m_wait(int r);
        case (r)
            1:       return 1;
            3:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_ext(int d, int r);
        return (d == 1) && (r == 2);
    endfunction

    function automatic int m_to(int d);
        return (d == 1) ? 8 : 255;
    endfunction

    function automatic int m_decode(int d, logic [31:0] a);
        for (int r = 0; r < 4; r++)
            if ((a & ~m_mask(d, r)) == m_base(r)) return r;
        return -1;
    endfunction

    // k = BUSY cycle (1-based) in which the slave raises ext_rdy; 0 = never.
    task automatic model_exp(input int d, input logic [31:0] a, input int k,
                             output logic [3:0] esel, output int en, output bit eerr);
        int r;
        r = m_decode(d, a);
        if (r < 0) begin
            esel = 4'b0000; en = 1; eerr = 1'b1;
        end else begin
            esel = 4'(1 << r);
            if (m_ext(d, r)) begin
                if (k > 0 && k <= m_to(d)) begin en = k + 1; eerr = 1'b0; end
                else begin en = m_to(d) + 1; eerr = 1'b1; end
            end else begin
                en = m_wait(r) + 2; eerr = 1'b0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Called at the sampling phase (#1 after a rising edge) with the DUT idle.
    task automatic txn(input int d, input logic [31:0] a, input int k, input bit clr_first,
                       input bit noise, input logic [3:0] esel, input int en, input bit eerr,
                       input string nm);
        int  r, got_n;
        bit  got_err, sel_ok, both;
        r = m_decode(d, a);
        got_n = 0; got_err = 1'b0; sel_ok = 1'b1; both = 1'b0;
        addr_d[d] = a; req_d[d] = 1'b1; fclr_d[d] = clr_first;
        for (int n = 1; n <= 400 && got_n == 0; n++) begin
            @(posedge clk); #1;
            fclr_d[d] = 1'b0;
            if (rdy_o[d] && err_o[d]) both = 1'b1;
            if (rdy_o[d] || err_o[d]) begin
                got_n = n; got_err = err_o[d];
                if (sel_o[d] != 4'b0000) sel_ok = 1'b0;
            end else if (sel_o[d] != esel) begin
                sel_ok = 1'b0;
            end
            if (noise) addr_d[d] = $urandom;
            ext_d[d] = noise ? 4'($urandom) : 4'b0000;
            if (r >= 0 && m_ext(d, r)) ext_d[d][r] = (n == k);
        end
        req_d[d] = 1'b0; ext_d[d] = 4'b0000;
        chk({nm, "_resp_cycle"}, 64'(got_n), 64'(en));
        chk({nm, "_err"}, 64'(got_err), 64'(eerr));
        chk({nm, "_sel"}, 64'(sel_ok), 64'd1);
        chk({nm, "_not_both"}, 64'(both), 64'd0);
        @(posedge clk); #1;
        chk({nm, "_pulse_len"}, {62'd0, rdy_o[d], err_o[d]}, 64'd0);
        if (clr_first) begin mfv[d] = 1'b0; mfa[d] = 32'h0; end
        if (eerr && !mfv[d]) begin mfv[d] = 1'b1; mfa[d] = a; end
        chk({nm, "_fault_valid"}, 64'(fv_o[d]), 64'(mfv[d]));
        chk({nm, "_fault_addr"}, 64'(fa_o[d]), 64'(mfa[d]));
    endtask

    task automatic clr_pulse(input int d, input string nm);
        fclr_d[d] = 1'b1;
        @(posedge clk); #1;
        fclr_d[d] = 1'b0;
        mfv[d] = 1'b0; mfa[d] = 32'h0;
        chk({nm, "_clr_valid"}, 64'(fv_o[d]), 64'd0);
        chk({nm, "_clr_addr"}, 64'(fa_o[d]), 64'd0);
    endtask

    typedef struct {
        int          d;
        logic [31:0] addr;
        int          k;
        bit          clr;
        logic [3:0]  sel;
        int          n;
        bit          err;
    } vec_t;

    initial begin : main
        vec_t        tbl[$];
        logic [3:0]  esel;
        int          en, r, k;
        bit          eerr, saw;
        logic [31:0] a;

        checks = 0; failures = 0;
        rst_n_d = 3'b000; req_d = '0; addr_d = '0; ext_d = '0; fclr_d = '0;
        for (int d = 0; d < 3; d++) begin mfv[d] = 1'b0; mfa[d] = 32'h0; end

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d_sel", d), 64'(sel_o[d]), 64'd0);
            chk($sformatf("rst%0d_resp", d), {62'd0, rdy_o[d], err_o[d]}, 64'd0);
            chk($sformatf("rst%0d_fault", d), {31'd0, fv_o[d], fa_o[d]}, 64'd0);
        end
        rst_n_d = 3'b111;
        repeat (4) @(posedge clk);
        #1;

        //                d  addr           k  clr sel      n  err
        tbl.push_back('{0, 32'h00000010, 0, 0, 4'b0001, 2, 0});
        tbl.push_back('{0, 32'h0BFFFFFC, 0, 0, 4'b1000, 4, 0});
        tbl.push_back('{0, 32'h0C000000, 0, 0, 4'b0000, 1, 1});
        tbl.push_back('{0, 32'h10000000, 0, 0, 4'b0000, 1, 1});
        tbl.push_back('{0, 32'h0400FFFF, 0, 0, 4'b0010, 3, 0});
        tbl.push_back('{0, 32'h04010010, 0, 0, 4'b0000, 1, 1});
        tbl.push_back('{0, 32'h04010004, 0, 0, 4'b0100, 2, 0});
        tbl.push_back('{0, 32'h20000000, 0, 1, 4'b0000, 1, 1});
        tbl.push_back('{1, 32'h04010004, 3, 0, 4'b0100, 4, 0});
        tbl.push_back('{1, 32'h04010004, 0, 0, 4'b0100, 9, 1});
        tbl.push_back('{1, 32'h04010008, 8, 0, 4'b0100, 9, 0});
        tbl.push_back('{1, 32'h04010000, 9, 0, 4'b0100, 9, 1});
        tbl.push_back('{1, 32'h04000000, 0, 0, 4'b0010, 3, 0});
        tbl.push_back('{2, 32'h04000000, 0, 0, 4'b0001, 2, 0});
        tbl.push_back('{2, 32'h04010004, 0, 0, 4'b0001, 2, 0});
        tbl.push_back('{2, 32'h08000000, 0, 0, 4'b1000, 4, 0});
        tbl.push_back('{2, 32'h0C000000, 0, 0, 4'b0000, 1, 1});

        foreach (tbl[i])
            txn(tbl[i].d, tbl[i].addr, tbl[i].k, tbl[i].clr, 1'b0,
                tbl[i].sel, tbl[i].n, tbl[i].err, $sformatf("vec%0d", i));

        clr_pulse(0, "hand_a");
        clr_pulse(1, "hand_b");

        // Reset asserted while a RAM access is in BUSY.
        addr_d[0] = 32'h08000000; req_d[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst_busy_sel", 64'(sel_o[0]), 64'b1000);
        #2 rst_n_d[0] = 1'b0;
        #1;
        chk("midrst_async_sel", 64'(sel_o[0]), 64'd0);
        req_d[0] = 1'b0;
        saw = 1'b0;
        repeat (3) begin @(posedge clk); #1; saw |= rdy_o[0] | err_o[0]; end
        rst_n_d[0] = 1'b1;
        repeat (4) begin @(posedge clk); #1; saw |= rdy_o[0] | err_o[0]; end
        chk("midrst_no_resp", 64'(saw), 64'd0);
        chk("midrst_sel_idle", 64'(sel_o[0]), 64'd0);
        mfv[0] = 1'b0; mfa[0] = 32'h0;
        txn(0, 32'h04000000, 0, 1'b0, 1'b0, 4'b0010, 3, 1'b0, "post_rst_io");

        // Random traffic: address and ext_rdy noise while BUSY must be ignored.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 50; i++) begin
                r = $urandom_range(0, 4);
                k = $urandom_range(0, 11);
                a = $urandom;
                if (r < 4) a = m_base(r) | (a & m_mask(d, r));
                model_exp(d, a, k, esel, en, eerr);
                txn(d, a, k, ($urandom_range(0, 7) == 0), 1'b1, esel, en, eerr,
                    $sformatf("rnd%0d_%0d", d, i));
                if ($urandom_range(0, 9) == 0) clr_pulse(d, $sformatf("rndclr%0d_%0d", d, i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
